// File: rtl/afe_l2_multi_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : afe_l2_pkg
// Description : Shared constants and helpers for the AFE L2 multi-channel
//               write-address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package afe_l2_pkg;

  // One L2 write carries one 32-bit sample word.
  localparam int unsigned BYTES_PER_WORD = 4;

  // Upper bound on the number of L2 channels a single generator can serve.
  localparam int unsigned MAX_L2_CHS = 32;

  // Index of the lowest set bit of a hit vector (0 when the vector is empty;
  // callers qualify the result with a reduction-OR of the same vector).
  function automatic logic [4:0] lowest_match_idx(input logic [MAX_L2_CHS-1:0] hit);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_L2_CHS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/afe_l2_multi_addr_gen_ch_ctx.sv
`default_nettype none
// ============================================================================
// Module      : afe_l2_ch_ctx
// Description : One L2 channel context: write address, remaining byte count,
//               decimation counter and enable, with clear/enable/advance.
// Revision    : 1.0 - initial release
// ============================================================================
module afe_l2_ch_ctx
  import afe_l2_pkg::*;
#(
  parameter int unsigned AWIDTH = 12,
  parameter int unsigned SWIDTH = 16,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AWIDTH-1:0] startaddr_i,
  input  logic [SWIDTH-1:0] size_i,
  input  logic              continuous_i,
  input  logic [DWIDTH-1:0] decim_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              hit_i,
  output logic [AWIDTH-1:0] curr_addr_o,
  output logic [SWIDTH-1:0] bytes_left_o,
  output logic              ch_en_o,
  output logic              issue_o,
  output logic              last_o
);

  typedef struct packed {
    logic [AWIDTH-1:0] curr_addr;
    logic [SWIDTH-1:0] bytes_left;
    logic [DWIDTH-1:0] decim_cnt;
    logic              en;
  } ch_state_t;

  localparam logic [AWIDTH-1:0] ADDR_STEP = AWIDTH'(BYTES_PER_WORD);
  localparam logic [SWIDTH-1:0] SIZE_STEP = SWIDTH'(BYTES_PER_WORD);
  localparam logic [AWIDTH-1:0] ADDR_MASK = ~AWIDTH'(BYTES_PER_WORD - 1);
  localparam logic [SWIDTH-1:0] SIZE_MASK = ~SWIDTH'(BYTES_PER_WORD - 1);

  ch_state_t         state_q;
  ch_state_t         state_d;
  logic [AWIDTH-1:0] start_al;
  logic [SWIDTH-1:0] size_al;

  // Word-aligned copies of the programmed start address and buffer size.
  assign start_al = startaddr_i & ADDR_MASK;
  assign size_al  = size_i & SIZE_MASK;

  // Next-state: clear beats enable, enable beats a sample hit in the same cycle.
  always_comb begin
    state_d = state_q;
    issue_o = 1'b0;
    last_o  = 1'b0;
    if (clr_i) begin
      state_d = '0;
    end else if (en_i) begin
      state_d.curr_addr  = start_al;
      state_d.bytes_left = size_al;
      state_d.decim_cnt  = '0;
      state_d.en         = (size_al != '0);
    end else if (hit_i && state_q.en) begin
      if (state_q.decim_cnt != '0) begin
        state_d.decim_cnt = state_q.decim_cnt - DWIDTH'(1);
      end else begin
        issue_o            = 1'b1;
        state_d.decim_cnt  = decim_i;
        state_d.curr_addr  = state_q.curr_addr + ADDR_STEP;
        state_d.bytes_left = state_q.bytes_left - SIZE_STEP;
        if (state_q.bytes_left == SIZE_STEP) begin
          last_o = 1'b1;
          if (continuous_i && (size_al != '0)) begin
            state_d.curr_addr  = start_al;
            state_d.bytes_left = size_al;
          end else begin
            state_d.en = 1'b0;
          end
        end
      end
    end
  end

  // Channel context register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign curr_addr_o  = state_q.curr_addr;
  assign bytes_left_o = state_q.bytes_left;
  assign ch_en_o      = state_q.en;

endmodule
`default_nettype wire

// File: rtl/afe_l2_multi_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : afe_l2_multi_addr_gen
// Description : L2 write-address generator with ADC-to-L2 channel mapping,
//               per-channel decimation, registered valid/ready write port and
//               saturating dropped-sample counter.
// Revision    : 1.0 - initial release
// ============================================================================
module afe_l2_multi_addr_gen
  import afe_l2_pkg::*;
#(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned L2_NUM_CHS     = 8,
  parameter int unsigned CH_ID_WIDTH    = 4,
  parameter int unsigned DECIM_WIDTH    = 8,
  parameter int unsigned DROP_CNT_WIDTH = 16,
  localparam int unsigned L2CH_WIDTH    = (L2_NUM_CHS > 1) ? $clog2(L2_NUM_CHS) : 1
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [L2_NUM_CHS-1:0][L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [L2_NUM_CHS-1:0][TRANS_SIZE-1:0]     cfg_size_i,
  input  logic [L2_NUM_CHS-1:0]                     cfg_continuous_i,
  input  logic [L2_NUM_CHS-1:0][CH_ID_WIDTH-1:0]    cfg_chid_i,
  input  logic [L2_NUM_CHS-1:0][DECIM_WIDTH-1:0]    cfg_decim_i,
  input  logic [L2_NUM_CHS-1:0]                     cfg_en_i,
  input  logic [L2_NUM_CHS-1:0]                     cfg_clr_i,
  output logic [L2_NUM_CHS-1:0][L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [L2_NUM_CHS-1:0][TRANS_SIZE-1:0]     cfg_bytes_left_o,
  output logic [L2_NUM_CHS-1:0]                     cfg_ch_en_o,
  input  logic                                      sample_valid_i,
  input  logic [CH_ID_WIDTH-1:0]                    sample_chid_i,
  output logic                                      sample_ready_o,
  output logic                                      wr_valid_o,
  output logic [L2_AWIDTH_NOAL-1:0]                 wr_addr_o,
  output logic [L2CH_WIDTH-1:0]                     wr_l2ch_o,
  input  logic                                      wr_ready_i,
  output logic [L2_NUM_CHS-1:0]                     ch_event_o,
  output logic [DROP_CNT_WIDTH-1:0]                 drop_cnt_o,
  input  logic                                      drop_cnt_clr_i
);

  logic [L2_NUM_CHS-1:0]                     ch_en;
  logic [L2_NUM_CHS-1:0]                     ch_hit;
  logic [L2_NUM_CHS-1:0]                     ch_issue;
  logic [L2_NUM_CHS-1:0]                     ch_last;
  logic [L2_NUM_CHS-1:0]                     chid_match;
  logic [L2_NUM_CHS-1:0][L2_AWIDTH_NOAL-1:0] ch_addr;
  logic                                      match_any;
  logic                                      sample_acc;
  logic [L2CH_WIDTH-1:0]                     sel_idx;

  logic                      wr_valid_q, wr_valid_d;
  logic [L2_AWIDTH_NOAL-1:0] wr_addr_q,  wr_addr_d;
  logic [L2CH_WIDTH-1:0]     wr_l2ch_q,  wr_l2ch_d;
  logic [L2_NUM_CHS-1:0]     ch_event_q, ch_event_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      run_q,      run_d;

  // run_q keeps sample_ready_o low while reset is held and for the reset edge.
  assign sample_ready_o = run_q & (~wr_valid_q | wr_ready_i);

  // Per-channel contexts.
  for (genvar g = 0; g < L2_NUM_CHS; g++) begin : g_ch
    afe_l2_ch_ctx #(
      .AWIDTH (L2_AWIDTH_NOAL),
      .SWIDTH (TRANS_SIZE),
      .DWIDTH (DECIM_WIDTH)
    ) u_ch_ctx (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .startaddr_i  (cfg_startaddr_i[g]),
      .size_i       (cfg_size_i[g]),
      .continuous_i (cfg_continuous_i[g]),
      .decim_i      (cfg_decim_i[g]),
      .en_i         (cfg_en_i[g]),
      .clr_i        (cfg_clr_i[g]),
      .hit_i        (ch_hit[g]),
      .curr_addr_o  (ch_addr[g]),
      .bytes_left_o (cfg_bytes_left_o[g]),
      .ch_en_o      (ch_en[g]),
      .issue_o      (ch_issue[g]),
      .last_o       (ch_last[g])
    );
  end

  // Route an accepted sample to the lowest-index enabled channel with its ID.
  always_comb begin
    sample_acc = sample_valid_i & sample_ready_o;
    for (int k = 0; k < int'(L2_NUM_CHS); k++) begin
      chid_match[k] = ch_en[k] & (cfg_chid_i[k] == sample_chid_i);
    end
    match_any = |chid_match;
    sel_idx   = L2CH_WIDTH'(lowest_match_idx(MAX_L2_CHS'(chid_match)));
    for (int k = 0; k < int'(L2_NUM_CHS); k++) begin
      ch_hit[k] = sample_acc & match_any & (sel_idx == L2CH_WIDTH'(k));
    end
  end

  // Output register, completion events and drop counter next-state. A write
  // is only loaded on an accepted sample, which implies the slot is free.
  always_comb begin
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_l2ch_d  = wr_l2ch_q;
    if (|ch_issue) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = ch_addr[sel_idx];
      wr_l2ch_d  = sel_idx;
    end else if (wr_ready_i) begin
      wr_valid_d = 1'b0;
    end
    ch_event_d = ch_last;
    drop_cnt_d = drop_cnt_q;
    if (drop_cnt_clr_i) begin
      drop_cnt_d = '0;
    end else if (sample_acc && !match_any && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
    run_d = 1'b1;
  end

  // Top-level state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_l2ch_q  <= '0;
      ch_event_q <= '0;
      drop_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_l2ch_q  <= wr_l2ch_d;
      ch_event_q <= ch_event_d;
      drop_cnt_q <= drop_cnt_d;
      run_q      <= run_d;
    end
  end

  assign cfg_curr_addr_o = ch_addr;
  assign cfg_ch_en_o     = ch_en;
  assign wr_valid_o      = wr_valid_q;
  assign wr_addr_o       = wr_addr_q;
  assign wr_l2ch_o       = wr_l2ch_q;
  assign ch_event_o      = ch_event_q;
  assign drop_cnt_o      = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_afe_l2_multi_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_afe_l2_multi_addr_gen
// Description : Self-checking bench for afe_l2_multi_addr_gen: directed vector
//               table, hand-written corner sequences and a randomized phase
//               checked every cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afe_l2_multi_addr_gen;

  localparam int N  = 8;
  localparam int AW = 12;
  localparam int TW = 16;
  localparam int CW = 4;
  localparam int DW = 8;
  localparam int DCW = 16;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0][AW-1:0] cfg_startaddr;
  logic [N-1:0][TW-1:0] cfg_size;
  logic [N-1:0]         cfg_cont;
  logic [N-1:0][CW-1:0] cfg_chid;
  logic [N-1:0][DW-1:0] cfg_decim;
  logic [N-1:0]         cfg_en;
  logic [N-1:0]         cfg_clr;
  logic [N-1:0][AW-1:0] curr_addr;
  logic [N-1:0][TW-1:0] bytes_left;
  logic [N-1:0]         ch_en;
  logic                 sample_valid;
  logic [CW-1:0]        sample_chid;
  logic                 sample_ready;
  logic                 wr_valid;
  logic [AW-1:0]        wr_addr;
  logic [LW-1:0]        wr_l2ch;
  logic                 wr_ready;
  logic [N-1:0]         ch_event;
  logic [DCW-1:0]       drop_cnt;
  logic                 drop_clr;

  always #5 clk = ~clk;

  afe_l2_multi_addr_gen #(
    .L2_AWIDTH_NOAL (AW),
    .TRANS_SIZE     (TW),
    .L2_NUM_CHS     (N),
    .CH_ID_WIDTH    (CW),
    .DECIM_WIDTH    (DW),
    .DROP_CNT_WIDTH (DCW)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cfg_startaddr_i  (cfg_startaddr),
    .cfg_size_i       (cfg_size),
    .cfg_continuous_i (cfg_cont),
    .cfg_chid_i       (cfg_chid),
    .cfg_decim_i      (cfg_decim),
    .cfg_en_i         (cfg_en),
    .cfg_clr_i        (cfg_clr),
    .cfg_curr_addr_o  (curr_addr),
    .cfg_bytes_left_o (bytes_left),
    .cfg_ch_en_o      (ch_en),
    .sample_valid_i   (sample_valid),
    .sample_chid_i    (sample_chid),
    .sample_ready_o   (sample_ready),
    .wr_valid_o       (wr_valid),
    .wr_addr_o        (wr_addr),
    .wr_l2ch_o        (wr_l2ch),
    .wr_ready_i       (wr_ready),
    .ch_event_o       (ch_event),
    .drop_cnt_o       (drop_cnt),
    .drop_cnt_clr_i   (drop_clr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the generator described as a list of channel buffers.
  // Each accepted sample is routed, decimated, and turned into a write word.
  // ---------------------------------------------------------------------------
  int         m_addr [N];
  int         m_left [N];
  int         m_skip [N];
  bit         m_en   [N];
  bit         m_wv;
  int         m_wa;
  int         m_wc;
  bit [N-1:0] m_evt;
  int         m_drop;
  bit         m_run;

  task automatic model_step();
    bit ready_now;
    bit accepted;
    int k;
    int size_w;
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        m_addr[c] = 0; m_left[c] = 0; m_skip[c] = 0; m_en[c] = 0;
      end
      m_wv = 0; m_wa = 0; m_wc = 0; m_evt = '0; m_drop = 0; m_run = 0;
      return;
    end
    ready_now = m_run && (!m_wv || wr_ready);
    accepted  = sample_valid && ready_now;
    m_evt     = '0;
    if (m_wv && wr_ready) m_wv = 0;
    k = -1;
    for (int c = N - 1; c >= 0; c--) begin
      if (m_en[c] && cfg_chid[c] == sample_chid) k = c;
    end
    if (accepted) begin
      if (k < 0) begin
        if (m_drop < 65535) m_drop = m_drop + 1;
      end else if (!cfg_clr[k] && !cfg_en[k]) begin
        if (m_skip[k] > 0) begin
          m_skip[k] = m_skip[k] - 1;
        end else begin
          m_skip[k] = int'(cfg_decim[k]);
          m_wv = 1; m_wa = m_addr[k]; m_wc = k;
          m_addr[k] = (m_addr[k] + 4) % 4096;
          m_left[k] = m_left[k] - 4;
          if (m_left[k] == 0) begin
            m_evt[k] = 1'b1;
            size_w = int'(cfg_size[k]) / 4 * 4;
            if (cfg_cont[k] && size_w != 0) begin
              m_addr[k] = int'(cfg_startaddr[k]) / 4 * 4;
              m_left[k] = size_w;
            end else begin
              m_en[k] = 0;
            end
          end
        end
      end
    end
    for (int c = 0; c < N; c++) begin
      if (cfg_clr[c]) begin
        m_addr[c] = 0; m_left[c] = 0; m_skip[c] = 0; m_en[c] = 0;
      end else if (cfg_en[c]) begin
        m_addr[c] = int'(cfg_startaddr[c]) / 4 * 4;
        m_left[c] = int'(cfg_size[c]) / 4 * 4;
        m_skip[c] = 0;
        m_en[c]   = (m_left[c] != 0);
      end
    end
    if (drop_clr) m_drop = 0;
    m_run = 1;
  endtask

  // Advance the model on every edge and compare all outputs just after it.
  always @(posedge clk) begin
    bit [N-1:0] en_vec;
    model_step();
    #1;
    for (int c = 0; c < N; c++) en_vec[c] = m_en[c];
    chk("model wr_valid", wr_valid, m_wv);
    chk("model wr_addr", wr_addr, 64'(m_wa));
    chk("model wr_l2ch", wr_l2ch, 64'(m_wc));
    chk("model ch_event", ch_event, en_vec & 0 | m_evt);
    chk("model ch_en", ch_en, en_vec);
    chk("model drop_cnt", drop_cnt, 64'(m_drop));
    chk("model sample_ready", sample_ready, m_run && (!m_wv || wr_ready));
    for (int c = 0; c < N; c++) begin
      chk($sformatf("model curr_addr[%0d]", c), curr_addr[c], 64'(m_addr[c]));
      chk($sformatf("model bytes_left[%0d]", c), bytes_left[c], 64'(m_left[c]));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus helpers: inputs change on the falling edge, directed
  // checks happen 2 time units after the following rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input bit v, input bit [CW-1:0] id, input bit rdy);
    @(negedge clk);
    sample_valid = v; sample_chid = id; wr_ready = rdy;
    cfg_en = '0; cfg_clr = '0; drop_clr = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input bit [N-1:0] en, input bit [N-1:0] clr, input bit dclr);
    @(negedge clk);
    sample_valid = 1'b0; wr_ready = 1'b1;
    cfg_en = en; cfg_clr = clr; drop_clr = dclr;
    @(posedge clk);
    #2;
  endtask

  typedef struct packed {
    bit          v;
    bit [CW-1:0] id;
    bit          rdy;
    bit          e_wv;
    bit [AW-1:0] e_addr;
    bit [N-1:0]  e_evt;
    bit [N-1:0]  e_en;
    bit [DCW-1:0] e_drop;
  } vec_t;

  vec_t tbl [13];

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].v, tbl[i].id, tbl[i].rdy);
      chk($sformatf("tbl[%0d] wr_valid", i), wr_valid, tbl[i].e_wv);
      chk($sformatf("tbl[%0d] wr_addr", i), wr_addr, tbl[i].e_addr);
      chk($sformatf("tbl[%0d] ch_event", i), ch_event, tbl[i].e_evt);
      chk($sformatf("tbl[%0d] ch_en", i), ch_en, tbl[i].e_en);
      chk($sformatf("tbl[%0d] drop_cnt", i), drop_cnt, tbl[i].e_drop);
    end
  endtask

  initial begin
    int n_wr;
    // One-shot buffer: ch0 <- chid 3, 0x100, 16 bytes; 5th sample is a drop.
    tbl[0]  = '{1'b1, 4'd3, 1'b1, 1'b1, 12'h100, 8'h00, 8'h01, 16'd0};
    tbl[1]  = '{1'b1, 4'd3, 1'b1, 1'b1, 12'h104, 8'h00, 8'h01, 16'd0};
    tbl[2]  = '{1'b1, 4'd3, 1'b1, 1'b1, 12'h108, 8'h00, 8'h01, 16'd0};
    tbl[3]  = '{1'b1, 4'd3, 1'b1, 1'b1, 12'h10C, 8'h01, 8'h00, 16'd0};
    tbl[4]  = '{1'b1, 4'd3, 1'b1, 1'b0, 12'h10C, 8'h00, 8'h00, 16'd1};
    tbl[5]  = '{1'b0, 4'd3, 1'b1, 1'b0, 12'h10C, 8'h00, 8'h00, 16'd1};
    // Same buffer in continuous mode: wraps back to 0x100, single event.
    tbl[6]  = '{1'b1, 4'd3, 1'b1, 1'b1, 12'h100, 8'h00, 8'h01, 16'd0};
    tbl[7]  = '{1'b1, 4'd3, 1'b1, 1'b1, 12'h104, 8'h00, 8'h01, 16'd0};
    tbl[8]  = '{1'b1, 4'd3, 1'b1, 1'b1, 12'h108, 8'h00, 8'h01, 16'd0};
    tbl[9]  = '{1'b1, 4'd3, 1'b1, 1'b1, 12'h10C, 8'h01, 8'h01, 16'd0};
    tbl[10] = '{1'b1, 4'd3, 1'b1, 1'b1, 12'h100, 8'h00, 8'h01, 16'd0};
    tbl[11] = '{1'b1, 4'd3, 1'b1, 1'b1, 12'h104, 8'h00, 8'h01, 16'd0};
    tbl[12] = '{1'b0, 4'd3, 1'b1, 1'b0, 12'h104, 8'h00, 8'h01, 16'd0};

    rst = 1'b1; sample_valid = 1'b0; sample_chid = '0; wr_ready = 1'b1;
    cfg_en = '0; cfg_clr = '0; drop_clr = 1'b0;
    cfg_startaddr = '0; cfg_size = '0; cfg_cont = '0; cfg_decim = '0;
    for (int c = 0; c < N; c++) cfg_chid[c] = 4'hF;

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    chk("rst wr_valid", wr_valid, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst ch_en", ch_en, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    chk("rst sample_ready", sample_ready, 0);
    chk("rst curr_addr any", |curr_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    chk("ready after reset", sample_ready, 1);

    // One-shot then continuous buffer on ch0.
    cfg_startaddr[0] = 12'h100; cfg_size[0] = 16'd16; cfg_chid[0] = 4'd3;
    pulse(8'h01, 8'h00, 1'b0);
    chk("cfg_en ch_en", ch_en, 8'h01);
    chk("cfg_en curr_addr", curr_addr[0], 12'h100);
    chk("cfg_en bytes_left", bytes_left[0], 16'd16);
    run_table(0, 5);
    cfg_cont[0] = 1'b1;
    pulse(8'h01, 8'h00, 1'b1);
    run_table(6, 12);

    // Decimation by 3: writes on samples 1, 4 and 7.
    cfg_decim[0] = 8'd2; cfg_size[0] = 16'h40;
    pulse(8'h01, 8'h00, 1'b0);
    n_wr = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 4'd3, 1'b1);
      chk($sformatf("decim sample %0d wr_valid", i + 1), wr_valid, (i % 3) == 0);
      if (wr_valid) begin
        chk($sformatf("decim sample %0d wr_addr", i + 1), wr_addr, 64'(12'h100 + 4 * n_wr));
        n_wr++;
      end
    end
    chk("decim write count", n_wr, 3);
    cfg_decim[0] = 8'd0;
    pulse(8'h00, 8'h01, 1'b0);
    chk("clr ch_en", ch_en, 8'h00);

    // Two channels share chid 5: lowest index wins until it is cleared.
    cfg_startaddr[1] = 12'h200; cfg_size[1] = 16'h40; cfg_cont[1] = 1'b1; cfg_chid[1] = 4'd5;
    cfg_startaddr[4] = 12'h403; cfg_size[4] = 16'h43; cfg_cont[4] = 1'b1; cfg_chid[4] = 4'd5;
    pulse(8'h12, 8'h00, 1'b0);
    step(1'b1, 4'd5, 1'b1);
    chk("prio l2ch", wr_l2ch, 1);
    chk("prio addr", wr_addr, 12'h200);
    pulse(8'h00, 8'h02, 1'b0);
    step(1'b1, 4'd5, 1'b1);
    chk("after clr l2ch", wr_l2ch, 4);
    chk("after clr addr", wr_addr, 12'h400);

    // Backpressure: the pending write holds for 5 cycles, then the next
    // accepted sample is issued the cycle after release.
    step(1'b0, 4'd5, 1'b1);
    step(1'b1, 4'd5, 1'b0);
    chk("bp load addr", wr_addr, 12'h404);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd5, 1'b0);
      chk("bp sample_ready", sample_ready, 0);
      chk("bp wr_valid", wr_valid, 1);
      chk("bp wr_addr", wr_addr, 12'h404);
      chk("bp wr_l2ch", wr_l2ch, 4);
    end
    step(1'b1, 4'd5, 1'b1);
    chk("bp release wr_valid", wr_valid, 1);
    chk("bp release wr_addr", wr_addr, 12'h408);

    // Reset with a write pending, then a sub-word size keeps the channel off.
    @(negedge clk);
    rst = 1'b1; sample_valid = 1'b0; wr_ready = 1'b0;
    @(posedge clk);
    #2;
    chk("mid rst wr_valid", wr_valid, 0);
    chk("mid rst wr_addr", wr_addr, 0);
    chk("mid rst wr_l2ch", wr_l2ch, 0);
    chk("mid rst ch_en", ch_en, 0);
    chk("mid rst sample_ready", sample_ready, 0);
    @(negedge clk);
    rst = 1'b0; wr_ready = 1'b1;
    @(posedge clk);
    #2;
    cfg_size[0] = 16'd3;
    pulse(8'h01, 8'h00, 1'b0);
    chk("size3 ch_en", ch_en, 0);
    chk("size3 bytes_left", bytes_left[0], 0);

    // Randomized phase, checked by the reference model every cycle.
    for (int c = 0; c < N; c++) begin
      cfg_startaddr[c] = AW'($urandom);
      cfg_size[c]      = TW'($urandom_range(0, 40));
      cfg_cont[c]      = 1'($urandom_range(0, 1));
      cfg_decim[c]     = DW'($urandom_range(0, 2));
      cfg_chid[c]      = CW'($urandom_range(0, 3));
    end
    for (int t = 0; t < 3000; t++) begin
      int c;
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        c = $urandom_range(0, N - 1);
        cfg_startaddr[c] = AW'($urandom);
        cfg_size[c]      = TW'($urandom_range(0, 40));
        cfg_cont[c]      = 1'($urandom_range(0, 1));
        cfg_decim[c]     = DW'($urandom_range(0, 2));
        cfg_chid[c]      = CW'($urandom_range(0, 3));
      end
      for (int j = 0; j < N; j++) begin
        cfg_en[j]  = ($urandom_range(0, 29) == 0);
        cfg_clr[j] = ($urandom_range(0, 59) == 0);
      end
      drop_clr     = ($urandom_range(0, 99) == 0);
      rst          = ($urandom_range(0, 499) == 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_chid  = CW'($urandom_range(0, 4));
      wr_ready     = ($urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    rst = 1'b0; cfg_en = '0; cfg_clr = '0; drop_clr = 1'b0; sample_valid = 1'b0;
    wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
